// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM decoder: FSM state encoding and
// counter saturation / duty clamp values derived from the duty resolution.
package pwm_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    STUCK     = 2'd2
  } pwm_state_e;

  // Counters are r+1 bits wide so a nominal 2^r period fits with headroom.
  function automatic int cnt_max(input int r);
    return (32'sd1 <<< (r + 1)) - 32'sd1;
  endfunction

  function automatic int duty_clamp(input int r);
    return (32'sd1 <<< r) - 32'sd1;
  endfunction

endpackage

// File: rtl/pwm_decoder_if.sv
// PWM capture bus: raw PWM input toward the decoder and the measurement
// report (duty, period, stuck flag, one-cycle valid strobe) back out.
interface pwm_decoder_if #(
  parameter int R = 8
);
  logic         pwm_in;
  logic [R-1:0] duty_out;
  logic [R:0]   period_out;
  logic         valid;
  logic         stuck;

  modport master (
    output pwm_in,
    input  duty_out,
    input  period_out,
    input  valid,
    input  stuck
  );

  modport slave (
    input  pwm_in,
    output duty_out,
    output period_out,
    output valid,
    output stuck
  );
endinterface

// File: rtl/pwm_edge_detect.sv
// Input conditioning and rising-edge detect for the PWM decoder.
// PWM_DECODER_SYNC_EN adds a two-flop synchronizer (2 cycles latency) ahead of the edge flop.
module pwm_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in_i,
  output logic pwm_s_o,
  output logic rise_o
);

`ifdef PWM_DECODER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pwm_in_i};
    end
  end

  assign pwm_s_o = sync_q[1];
`else
  assign pwm_s_o = pwm_in_i;
`endif

  logic p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q <= 1'b0;
    end else begin
      p_q <= pwm_s_o;
    end
  end

  assign rise_o = pwm_s_o & ~p_q;

endmodule

// File: rtl/pwm_decoder.sv
// Measures period and high time of an incoming PWM waveform between rising edges,
// reporting duty/period with a one-cycle strobe and flagging inputs stuck high or low.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int R = 8
) (
  input  logic          clk,
  input  logic          reset,
  pwm_decoder_if.slave  bus
);

  localparam int         CW    = R + 1;
  localparam logic [R:0] MAX   = CW'(cnt_max(R));
  localparam logic [R:0] ONE   = CW'(1);
  localparam logic [R-1:0] CLAMP = R'(duty_clamp(R));

  logic pwm_s;
  logic rise;

  pwm_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .pwm_in_i (bus.pwm_in),
    .pwm_s_o  (pwm_s),
    .rise_o   (rise)
  );

  logic [R:0] per_q, per_d;
  logic [R:0] hi_q, hi_d;

  // A rise restarts both counts at 1 so the rising cycle itself is part of the new period.
  always_comb begin
    per_d = per_q;
    hi_d  = hi_q;
    if (rise) begin
      per_d = ONE;
      hi_d  = ONE;
    end else begin
      if (per_q != MAX) begin
        per_d = per_q + ONE;
      end
      if (pwm_s && (hi_q != MAX)) begin
        hi_d = hi_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_q <= '0;
      hi_q  <= '0;
    end else begin
      per_q <= per_d;
      hi_q  <= hi_d;
    end
  end

  logic [R-1:0] duty_meas;
  assign duty_meas = (hi_q > {1'b0, CLAMP}) ? CLAMP : hi_q[R-1:0];

  pwm_state_e   state_q;
  logic [R-1:0] duty_q;
  logic [R:0]   period_q;
  logic         valid_q;
  logic         stuck_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_EDGE;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        WAIT_EDGE, MEASURE: begin
          // A rise coinciding with saturation is a genuine edge, not a timeout.
          if (rise) begin
            if (state_q == MEASURE) begin
              duty_q   <= duty_meas;
              period_q <= per_q;
              stuck_q  <= 1'b0;
              valid_q  <= 1'b1;
            end
            state_q <= MEASURE;
          end else if (per_q == MAX) begin
            duty_q   <= pwm_s ? CLAMP : '0;
            period_q <= '0;
            stuck_q  <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= STUCK;
          end
        end
        STUCK: begin
          if (rise) begin
            state_q <= MEASURE;
          end
        end
        default: state_q <= WAIT_EDGE;
      endcase
    end
  end

  assign bus.duty_out   = duty_q;
  assign bus.period_out = period_q;
  assign bus.valid      = valid_q;
  assign bus.stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: a reference model tracks rising edges and high
// time per period, queues expected reports with their edge index, and a monitor checks them.
module tb_pwm_decoder;

  localparam int R    = 8;
  localparam int MAXC = (1 << (R + 1)) - 1;
  localparam int CLMP = (1 << R) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pwm_decoder_if #(.R(R)) bus ();

  pwm_decoder #(.R(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int duty;
    int period;
    int stuck;
    int at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // Reference model: edge-indexed view of the conditioned input.
  bit m_prev, m_h1, m_h2;
  bit m_armed, m_timed_out;
  int m_anchor, m_hi;

  task automatic model_clear();
    m_prev = 0; m_h1 = 0; m_h2 = 0;
    m_armed = 0; m_timed_out = 0;
    m_anchor = cyc + 1;
    m_hi = 0;
  endtask

  // Drive one value for the coming clock edge and predict that edge's report.
  task automatic step(input bit v);
    bit   s;
    int   k;
    exp_t e;
    k = cyc + 1;
`ifdef PWM_DECODER_SYNC_EN
    s = m_h2; m_h2 = m_h1; m_h1 = v;
`else
    s = v;
`endif
    if (s && !m_prev) begin
      if (m_armed) begin
        e.duty = (m_hi > CLMP) ? CLMP : m_hi;
        e.period = k - m_anchor;
        e.stuck = 0;
        e.at = k;
        q.push_back(e);
      end
      m_armed = 1; m_timed_out = 0; m_anchor = k; m_hi = 1;
    end else begin
      if (!m_timed_out && (k - m_anchor == MAXC)) begin
        e.duty = s ? CLMP : 0;
        e.period = 0;
        e.stuck = 1;
        e.at = k;
        q.push_back(e);
        m_timed_out = 1;
        m_armed = 0;
      end
      m_hi += int'(s);
    end
    m_prev = s;
    bus.pwm_in = v;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse(input int hi, input int per);
    for (int i = 0; i < hi; i++) step(1'b1);
    for (int i = 0; i < per - hi; i++) step(1'b0);
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (bus.valid !== 1'b0 || bus.stuck !== 1'b0 || bus.duty_out !== '0 || bus.period_out !== '0) begin
      fails++;
      $display("FAIL %s: valid=%0b stuck=%0b duty=%0d period=%0d, required all 0",
               name, bus.valid, bus.stuck, bus.duty_out, bus.period_out);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset_outputs");
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b0;
    q.delete();
    model_clear();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      while (q.size() > 0 && q[0].at < cyc) begin
        checks++;
        fails++;
        $display("FAIL missing_report: no valid at edge %0d, required duty=%0d period=%0d stuck=%0d",
                 q[0].at, q[0].duty, q[0].period, q[0].stuck);
        void'(q.pop_front());
      end
      if (bus.valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: edge %0d duty=%0d period=%0d stuck=%0b, required no strobe",
                   cyc, bus.duty_out, bus.period_out, bus.stuck);
        end else begin
          e = q.pop_front();
          if (e.at != cyc || e.duty != int'(bus.duty_out) ||
              e.period != int'(bus.period_out) || e.stuck != int'(bus.stuck)) begin
            fails++;
            $display("FAIL report: edge %0d duty=%0d period=%0d stuck=%0b, required edge %0d duty=%0d period=%0d stuck=%0d",
                     cyc, bus.duty_out, bus.period_out, bus.stuck, e.at, e.duty, e.period, e.stuck);
          end
        end
      end
    end
  end

  initial begin
    int per, hi;
    bus.pwm_in = 1'b0;
    #1;
    check_zero_outputs("reset_state");
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b0;
    model_clear();

    // Held low from reset: one stuck report, then silence.
    repeat (530) step(1'b0);

    repeat (5) pulse(171, 256);
    repeat (3) pulse(1, 256);
    repeat (3) pulse(255, 256);

    // Stuck high, then recovery needs two rises before a report.
    repeat (600) step(1'b1);
    repeat (10) step(1'b0);
    pulse(100, 256);
    pulse(100, 256);
    pulse(40, 256);

    // Reset in the middle of a high phase.
    repeat (2) pulse(171, 256);
    repeat (50) step(1'b1);
    do_reset(3);
    repeat (3) pulse(60, 200);

    pulse(200, 300);
    pulse(280, 300);
    pulse(200, 300);

    // Rise exactly at counter saturation, then one cycle too late.
    pulse(10, 511);
    pulse(10, 512);
    pulse(5, 100);
    pulse(5, 100);

    repeat (30) begin
      per = int'($urandom_range(540, 2));
      hi  = int'($urandom_range(per - 1, 1));
      pulse(hi, per);
    end
    repeat (20) step(1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected reports outstanding, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
